// File: rtl/mw_controller.sv
// mw_controller -- microwave-oven front-panel controller.
//
// Keypad digits shift into an mm:ss BCD time register from the right. Once
// started, the time counts down at 1 Hz while the magnetron is enabled. The
// door and stop inputs interlock the magnetron. Four 7-segment displays
// always show the current contents of the time register.
//
// Ports:
//   clk            system clock, rising edge
//   clear          synchronous active-high reset / panel CLEAR
//   keypad[9:0]    one-hot digit keys, bit i = digit i
//   startn         start, active-low, level-sampled
//   stopn          stop/pause, active-low, level-sampled
//   door_closed    1 = door closed
//   mag_on         magnetron enable (registered)
//   sec_ones_segs  seconds-ones segments  (bit0=a .. bit6=g, active-high)
//   sec_tens_segs  seconds-tens segments
//   min_ones_segs  minutes-ones segments
//   min_tens_segs  minutes-tens segments
module mw_controller #(
  parameter int CLK_HZ = 100
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       mag_on,
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] min_ones_segs,
  output logic [6:0] min_tens_segs
);

  localparam int PRE_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       mt_q, mo_q, st_q, so_q;
  logic             key_prev_q;
  logic [PRE_W-1:0] presc_q;
  logic             mag_on_d;

  logic             key_valid;
  logic [3:0]       key_digit;
  logic             key_accept;
  logic             tick;
  logic             cook_dec;
  logic [15:0]      time_dec;
  logic             time_zero;
  logic             dec_zero;
  logic             start_ok;

  // 7-segment encoding, bit0=a .. bit6=g
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Index of the set bit in a one-hot key vector
  function automatic logic [3:0] key_index(input logic [9:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

  // One-second decrement of {mt,mo,st,so}. Borrowing into the seconds-tens
  // digit reloads it with 5, so entries like 00:70 drain through 00:59.
  function automatic logic [15:0] time_minus_1(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else if (mo != 4'd0) begin
      mo = mo - 4'd1;
      st = 4'd5;
      so = 4'd9;
    end else if (mt != 4'd0) begin
      mt = mt - 4'd1;
      mo = 4'd9;
      st = 4'd5;
      so = 4'd9;
    end
    return {mt, mo, st, so};
  endfunction

  // Keys are edge-detected on "a valid key is present"; multi-key chords
  // count as no key at all.
  assign key_valid  = $onehot(keypad);
  assign key_digit  = key_index(keypad);
  assign key_accept = key_valid && !key_prev_q && (state_q != ST_COOK);

  assign tick      = (state_q == ST_COOK) && (presc_q == PRE_MAX);
  // A tick landing on the same cycle as a door-open or stop is discarded.
  assign cook_dec  = tick && door_closed && stopn;
  assign time_dec  = time_minus_1({mt_q, mo_q, st_q, so_q});
  assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
  assign dec_zero  = (time_dec == 16'h0000);
  assign start_ok  = !startn && stopn && door_closed && !time_zero;

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_SET;
      mag_on  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_on  <= mag_on_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SET, ST_PAUSE: begin
        if (start_ok) state_d = ST_COOK;
      end
      ST_COOK: begin
        if (!door_closed)           state_d = ST_PAUSE;
        else if (!stopn)            state_d = ST_PAUSE;
        else if (tick && dec_zero)  state_d = ST_SET;
      end
      default: state_d = ST_SET;
    endcase
  end

  // Output logic: mag_on is registered from the state being entered, so it
  // tracks COOK with no extra cycle of latency.
  always_comb begin
    mag_on_d = (state_d == ST_COOK);
  end

  // Prescaler runs only while cooking; any partial second is lost on exit.
  always_ff @(posedge clk) begin
    if (clear || state_q != ST_COOK) begin
      presc_q <= '0;
    end else if (presc_q == PRE_MAX) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Time register and key edge tracker
  always_ff @(posedge clk) begin
    if (clear) begin
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      key_prev_q <= 1'b0;
    end else begin
      key_prev_q <= key_valid;
      if (key_accept) begin
        mt_q <= mo_q;
        mo_q <= st_q;
        st_q <= so_q;
        so_q <= key_digit;
      end else if (cook_dec) begin
        {mt_q, mo_q, st_q, so_q} <= time_dec;
      end
    end
  end

  assign sec_ones_segs = seg7(so_q);
  assign sec_tens_segs = seg7(st_q);
  assign min_ones_segs = seg7(mo_q);
  assign min_tens_segs = seg7(mt_q);

endmodule

// File: tb/tb_mw_controller.sv
// tb_mw_controller -- scoreboard bench for mw_controller.
// Stimulus pushes expected {mag_on, mm:ss} records into a queue; a monitor
// on the falling clock edge pops each record and compares it with the DUT.
module tb_mw_controller;

  localparam int H = 10;

  logic       clk = 1'b0;
  logic       clear;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       mag_on;
  logic [6:0] sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        mag;
    logic [15:0] bcd;
  } exp_t;

  exp_t sb[$];

  mw_controller #(.CLK_HZ(H)) dut (
    .clk           (clk),
    .clear         (clear),
    .keypad        (keypad),
    .startn        (startn),
    .stopn         (stopn),
    .door_closed   (door_closed),
    .mag_on        (mag_on),
    .sec_ones_segs (sec_ones_segs),
    .sec_tens_segs (sec_tens_segs),
    .min_ones_segs (min_ones_segs),
    .min_tens_segs (min_tens_segs)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  // Monitor
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [27:0] want, got;
      e = sb.pop_front();
      want = {seg_ref(e.bcd[15:12]), seg_ref(e.bcd[11:8]),
              seg_ref(e.bcd[7:4]), seg_ref(e.bcd[3:0])};
      got  = {min_tens_segs, min_ones_segs, sec_tens_segs, sec_ones_segs};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s segs: got %h required %h (time %h)", e.name, got, want, e.bcd);
      end
      checks++;
      if (mag_on !== e.mag) begin
        errors++;
        $display("FAIL %s mag_on: got %b required %b", e.name, mag_on, e.mag);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic mag, input logic [15:0] bcd);
    exp_t e;
    e.name = name;
    e.mag  = mag;
    e.bcd  = bcd;
    sb.push_back(e);
  endtask

  task automatic press(input int d);
    keypad = 10'(1) << d;
    cyc(1);
    keypad = '0;
    cyc(1);
  endtask

  initial begin
    clear       = 1'b1;
    keypad      = '0;
    startn      = 1'b1;
    stopn       = 1'b1;
    door_closed = 1'b1;
    cyc(1);
    clear = 1'b0;
    expect_now("reset", 1'b0, 16'h0000);

    // chord of two keys enters nothing
    keypad = 10'b0000000011;
    cyc(2);
    keypad = '0;
    cyc(1);
    expect_now("chord_set", 1'b0, 16'h0000);

    // held key enters one digit
    keypad = 10'(1) << 1;
    cyc(10);
    expect_now("hold_key1", 1'b0, 16'h0001);
    keypad = '0;
    cyc(2);
    keypad = 10'(1) << 2;
    cyc(3);
    keypad = '0;
    cyc(1);
    expect_now("entry_12", 1'b0, 16'h0012);

    // cook
    startn = 1'b0;
    cyc(1);
    expect_now("start", 1'b1, 16'h0012);
    cyc(8*H - 1);
    expect_now("cook_7s", 1'b1, 16'h0005);
    cyc(1);
    expect_now("cook_8s", 1'b1, 16'h0004);

    // door open pauses, holding start resumes on close
    door_closed = 1'b0;
    cyc(1);
    expect_now("door_open", 1'b0, 16'h0004);
    cyc(2*H - 1);
    expect_now("door_2s", 1'b0, 16'h0004);
    door_closed = 1'b1;
    cyc(1);
    expect_now("resume", 1'b1, 16'h0004);
    cyc(3*H);
    expect_now("resume_3s", 1'b1, 16'h0001);

    // stop pauses even with start held
    stopn = 1'b0;
    cyc(1);
    expect_now("stop", 1'b0, 16'h0001);
    cyc(H + 2);
    expect_now("stop_hold", 1'b0, 16'h0001);

    // expiry
    stopn = 1'b1;
    cyc(1);
    expect_now("resume2", 1'b1, 16'h0001);
    cyc(H - 1);
    expect_now("pre_expire", 1'b1, 16'h0001);
    cyc(1);
    expect_now("expire", 1'b0, 16'h0000);
    cyc(5);
    expect_now("start_zero", 1'b0, 16'h0000);

    // borrow from 00:70
    startn = 1'b1;
    clear  = 1'b1;
    cyc(1);
    clear = 1'b0;
    press(7);
    press(0);
    expect_now("entry_70", 1'b0, 16'h0070);
    startn = 1'b0;
    cyc(1);
    cyc(H);
    expect_now("borrow_69", 1'b1, 16'h0069);
    cyc(10*H);
    expect_now("borrow_59", 1'b1, 16'h0059);

    // clear mid-cook
    clear = 1'b1;
    cyc(1);
    clear  = 1'b0;
    startn = 1'b1;
    expect_now("clear_cook", 1'b0, 16'h0000);

    // minute borrow
    press(1);
    press(0);
    press(0);
    expect_now("entry_0100", 1'b0, 16'h0100);
    startn = 1'b0;
    cyc(1);
    cyc(H);
    expect_now("min_borrow", 1'b1, 16'h0059);

    // key ignored while cooking
    keypad = 10'(1) << 3;
    cyc(1);
    keypad = '0;
    cyc(1);
    expect_now("key_in_cook", 1'b1, 16'h0059);

    // keys in PAUSE: chord ignored, single key shifts in
    startn = 1'b1;
    stopn  = 1'b0;
    cyc(1);
    keypad = 10'b0000000011;
    cyc(2);
    keypad = '0;
    cyc(1);
    expect_now("chord_pause", 1'b0, 16'h0059);
    press(5);
    expect_now("key_pause", 1'b0, 16'h0595);

    cyc(2);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
